reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_if.sv | 25 ++
 rtl/reorder_buffer.sv | 54 +++++
 2 files changed

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: ROB bus (slave = ROB; alloc/wb in, alloc grant/commit/flush/count out; master = pipeline side)
interface reorder_buffer_if;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [4:0]  alloc_rob_idx;
  logic        wb_valid;
  logic [4:0]  wb_rob_idx;
  logic [31:0] wb_value;
  logic        wb_mispredict;
  logic        commit_valid;
  logic [4:0]  commit_rd;
  logic [31:0] commit_value;
  logic [4:0]  commit_rob_idx;
  logic        flush_all;
  logic [5:0]  count;
  modport slave (
    input  alloc_valid, alloc_rd, wb_valid, wb_rob_idx, wb_value, wb_mispredict,
    output alloc_ready, alloc_rob_idx, commit_valid, commit_rd, commit_value, commit_rob_idx, flush_all, count
  );
  modport master (
    output alloc_valid, alloc_rd, wb_valid, wb_rob_idx, wb_value, wb_mispredict,
    input  alloc_ready, alloc_rob_idx, commit_valid, commit_rd, commit_value, commit_rob_idx, flush_all, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: 32-entry in-order reorder buffer; ports clk, rst (sync, active-high), bus (reorder_buffer_if.slave)
module reorder_buffer (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);
  logic [31:0] valid, done, misp;
  logic [4:0]  rd [32];
  logic [31:0] value [32];
  logic [4:0]  head, tail;
  logic [5:0]  count;
  logic        commit, flush, alloc_fire;
  always_comb begin
    commit = (count != 6'd0) && valid[head] && done[head];
    flush = commit && misp[head];
    alloc_fire = bus.alloc_valid && (count != 6'd32) && !flush;
  end
  assign bus.alloc_ready = (count != 6'd32) && !flush;
  assign bus.alloc_rob_idx = tail;
  assign bus.commit_valid = commit;
  assign bus.commit_rd = commit ? rd[head] : 5'd0;
  assign bus.commit_value = commit ? value[head] : 32'd0;
  assign bus.commit_rob_idx = commit ? head : 5'd0;
  assign bus.flush_all = flush;
  assign bus.count = count;
  // later assignments win: allocation overrides a same-index writeback
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (bus.wb_valid && valid[bus.wb_rob_idx]) begin
        done[bus.wb_rob_idx] <= 1'b1;
        misp[bus.wb_rob_idx] <= bus.wb_mispredict;
        value[bus.wb_rob_idx] <= bus.wb_value;
      end
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        done[tail] <= 1'b0;
        misp[tail] <= 1'b0;
        rd[tail] <= bus.alloc_rd;
        value[tail] <= 32'd0;
        tail <= tail + 5'd1;
      end
      if (commit) begin
        valid[head] <= 1'b0;
        head <= head + 5'd1;
      end
      count <= count + {5'd0, alloc_fire} - {5'd0, commit};
    end
  end
endmodule
